// File: rtl/uart_pkt_pkg.sv
// Shared types and defaults for the UART packet parser.
package uart_pkt_pkg;

  typedef enum logic [2:0] {
    HUNT,
    LEN,
    PAYLOAD,
    CHK,
    DRAIN
  } state_e;

  localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

  typedef enum logic [2:0] {
    ERR_NONE,
    ERR_CHK,
    ERR_LEN,
    ERR_TIMEOUT,
    ERR_FRAME
  } err_e;

endpackage

// File: rtl/uart_pkt_buf.sv
// Payload buffer: synchronous single-port write, asynchronous read.
module uart_pkt_buf #(
  parameter int DEPTH = 16,
  parameter int IDX_W = 4
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [7:0]       wr_data,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [7:0]       rd_data
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= wr_data;
  end

  assign rd_data = mem[rd_idx];

endmodule

// File: rtl/uart_pkt_parser.sv
// Frames RX FIFO bytes into SYNC/LEN/payload/CHK packets and releases verified
// payloads on a valid/ready stream.
//
// state   | meaning
// HUNT    | dropping bytes until SYNC_BYTE
// LEN     | waiting for the length byte
// PAYLOAD | storing payload bytes, accumulating XOR checksum
// CHK     | comparing the checksum byte
// DRAIN   | streaming the verified payload, RX FIFO held off
module uart_pkt_parser
  import uart_pkt_pkg::*;
#(
  parameter int         DATA_BITS      = 8,
  parameter int         MAX_LEN        = 16,
  parameter logic [7:0] SYNC_BYTE      = SYNC_DEFAULT,
  parameter int         TIMEOUT_CYCLES = 10000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] rx_data,
  input  logic                 rx_valid,
  output logic                 rx_rd_en,
  input  logic                 rx_frame_error,
  output logic [DATA_BITS-1:0] pkt_data,
  output logic                 pkt_valid,
  input  logic                 pkt_ready,
  output logic                 pkt_last,
  output logic [7:0]           pkt_len,
  output logic                 err_chk,
  output logic                 err_len,
  output logic                 err_timeout,
  output logic                 err_frame,
  output logic [15:0]          pkt_count
);

  localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  // Abort on the idle clock that would bring the counter to TIMEOUT_CYCLES-1.
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 2);

  state_e                 state;
  err_e                   err_q;
  logic [7:0]             len_reg;
  logic [DATA_BITS-1:0]   chk;
  logic [IDX_W-1:0]       wr_idx;
  logic [IDX_W-1:0]       rd_idx;
  logic [TMO_W-1:0]       tmo_cnt;
  logic [DATA_BITS-1:0]   buf_rd;
  logic                   in_pkt;
  logic                   consumed;
  logic                   frame_hit;
  logic                   timeout_hit;
  logic                   buf_wr;

  assign in_pkt      = (state == LEN) || (state == PAYLOAD) || (state == CHK);
  assign rx_rd_en    = rx_valid && (state != DRAIN);
  assign consumed    = rx_valid && rx_rd_en;
  assign frame_hit   = in_pkt && rx_frame_error;
  assign timeout_hit = in_pkt && !consumed && (tmo_cnt == TMO_LAST);
  assign buf_wr      = (state == PAYLOAD) && consumed && !frame_hit;

  uart_pkt_buf #(
    .DEPTH (MAX_LEN),
    .IDX_W (IDX_W)
  ) u_buf (
    .clk     (clk),
    .wr_en   (buf_wr),
    .wr_idx  (wr_idx),
    .wr_data (rx_data),
    .rd_idx  (rd_idx),
    .rd_data (buf_rd)
  );

  // Stream outputs are forced to zero outside DRAIN so they follow reset.
  assign pkt_valid = (state == DRAIN);
  assign pkt_data  = pkt_valid ? buf_rd : '0;
  assign pkt_len   = pkt_valid ? len_reg : '0;
  assign pkt_last  = pkt_valid && (8'(rd_idx) == len_reg - 8'd1);

  assign err_chk     = (err_q == ERR_CHK);
  assign err_len     = (err_q == ERR_LEN);
  assign err_timeout = (err_q == ERR_TIMEOUT);
  assign err_frame   = (err_q == ERR_FRAME);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= HUNT;
      err_q     <= ERR_NONE;
      len_reg   <= '0;
      chk       <= '0;
      wr_idx    <= '0;
      rd_idx    <= '0;
      tmo_cnt   <= '0;
      pkt_count <= '0;
    end else begin
      err_q   <= ERR_NONE;
      tmo_cnt <= (in_pkt && !consumed) ? tmo_cnt + TMO_W'(1) : '0;
      if (frame_hit) begin
        state <= HUNT;
        err_q <= ERR_FRAME;
      end else if (timeout_hit) begin
        state <= HUNT;
        err_q <= ERR_TIMEOUT;
      end else begin
        case (state)
          HUNT: begin
            if (consumed && rx_data == SYNC_BYTE) state <= LEN;
          end
          LEN: begin
            if (consumed) begin
              if (rx_data == '0 || rx_data > 8'(MAX_LEN)) begin
                err_q <= ERR_LEN;
                state <= HUNT;
              end else begin
                len_reg <= rx_data;
                chk     <= rx_data;
                wr_idx  <= '0;
                state   <= PAYLOAD;
              end
            end
          end
          PAYLOAD: begin
            if (consumed) begin
              chk    <= chk ^ rx_data;
              wr_idx <= wr_idx + IDX_W'(1);
              if (8'(wr_idx) == len_reg - 8'd1) state <= CHK;
            end
          end
          CHK: begin
            if (consumed) begin
              if (rx_data == chk) begin
                rd_idx <= '0;
                state  <= DRAIN;
              end else begin
                err_q <= ERR_CHK;
                state <= HUNT;
              end
            end
          end
          DRAIN: begin
            if (pkt_ready) begin
              rd_idx <= rd_idx + IDX_W'(1);
              if (pkt_last) begin
                pkt_count <= pkt_count + 16'd1;
                state     <= HUNT;
              end
            end
          end
          default: state <= HUNT;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_pkt_parser.sv
// Scoreboard bench for uart_pkt_parser: directed packets, monitor-side checking.
module tb_uart_pkt_parser;

  localparam int TMO = 10000;

  typedef logic [7:0] byte_t;
  typedef struct packed {
    logic [7:0] data;
    logic       last;
    logic [7:0] len;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_rd_en;
  logic        rx_frame_error;
  logic [7:0]  pkt_data;
  logic        pkt_valid;
  logic        pkt_ready;
  logic        pkt_last;
  logic [7:0]  pkt_len;
  logic        err_chk;
  logic        err_len;
  logic        err_timeout;
  logic        err_frame;
  logic [15:0] pkt_count;

  int   tests = 0;
  int   failed = 0;
  int   ready_mode = 0;
  int   cnt_model = 0;
  exp_t exp_q[$];
  logic [3:0] exp_err[$];
  byte_t seq[$];

  uart_pkt_parser #(
    .DATA_BITS      (8),
    .MAX_LEN        (16),
    .SYNC_BYTE      (8'hA5),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .rx_data        (rx_data),
    .rx_valid       (rx_valid),
    .rx_rd_en       (rx_rd_en),
    .rx_frame_error (rx_frame_error),
    .pkt_data       (pkt_data),
    .pkt_valid      (pkt_valid),
    .pkt_ready      (pkt_ready),
    .pkt_last       (pkt_last),
    .pkt_len        (pkt_len),
    .err_chk        (err_chk),
    .err_len        (err_len),
    .err_timeout    (err_timeout),
    .err_frame      (err_frame),
    .pkt_count      (pkt_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ready pattern: 0 = always ready, 1 = toggle every cycle, 2 = never ready
  initial begin
    pkt_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        1:       pkt_ready = ~pkt_ready;
        2:       pkt_ready = 1'b0;
        default: pkt_ready = 1'b1;
      endcase
    end
  end

  // monitor: stream handshakes, error pulses, hold stability, FIFO hold-off
  logic       hold_pending = 1'b0;
  logic [8:0] held;
  always @(negedge clk) begin
    logic [3:0] ev;
    exp_t e;
    ev = {err_frame, err_timeout, err_len, err_chk};
    if (ev != 4'b0) begin
      if (exp_err.size() == 0) check("err_unexpected", ev, 0);
      else check("err_code", ev, exp_err.pop_front());
    end
    if (pkt_valid) begin
      check("rd_en_in_drain", rx_rd_en, 0);
      check("valid_expected", exp_q.size() != 0, 1);
      if (hold_pending) check("hold_stable", {pkt_last, pkt_data}, held);
      if (pkt_ready && exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("pkt_beat", {pkt_data, pkt_last, pkt_len}, e);
      end
    end
    hold_pending = pkt_valid && !pkt_ready;
    held = {pkt_last, pkt_data};
  end

  task automatic send(input byte_t b, input bit fe = 1'b0);
    int n = 0;
    rx_data = b;
    rx_valid = 1'b1;
    rx_frame_error = fe;
    @(negedge clk);
    while (!rx_rd_en && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("rd_en_wait", rx_rd_en, 1);
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    rx_frame_error = 1'b0;
  endtask

  task automatic send_seq(input byte_t s[$]);
    foreach (s[i]) send(s[i]);
  endtask

  task automatic expect_pkt(input byte_t p[$]);
    exp_t e;
    foreach (p[i]) begin
      e.data = p[i];
      e.last = (i == p.size() - 1);
      e.len  = 8'(p.size());
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    check("drain_done", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int idle;
    int n;
    rst = 1'b0;
    rx_data = 8'h00;
    rx_valid = 1'b0;
    rx_frame_error = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs",
          {pkt_valid, rx_rd_en, pkt_last, err_chk, err_len, err_timeout, err_frame, pkt_data, pkt_len, pkt_count},
          0);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // good packet
    seq = '{8'h11, 8'h22, 8'h33};
    expect_pkt(seq);
    seq = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03};
    send_seq(seq);
    wait_drain(50);
    cnt_model++;
    check("count_good", pkt_count, cnt_model);

    // noise then bad checksum, then recovery
    exp_err.push_back(4'b0001);
    seq = '{8'h00, 8'hFF, 8'hA5, 8'h02, 8'hAA, 8'hBB, 8'h00};
    send_seq(seq);
    seq = '{8'h5A};
    expect_pkt(seq);
    seq = '{8'hA5, 8'h01, 8'h5A, 8'h5B};
    send_seq(seq);
    wait_drain(50);
    cnt_model++;
    check("count_after_chk", pkt_count, cnt_model);

    // length errors at both bounds
    exp_err.push_back(4'b0010);
    exp_err.push_back(4'b0010);
    seq = '{8'hA5, 8'h00, 8'hA5, 8'h11};
    send_seq(seq);
    repeat (2) @(posedge clk);
    #1;
    check("len_err_drained", exp_err.size(), 0);

    // inter-byte timeout
    exp_err.push_back(4'b0100);
    seq = '{8'hA5, 8'h02, 8'h7E};
    send_seq(seq);
    idle = 0;
    while (!err_timeout && idle < 2 * TMO) begin
      @(posedge clk);
      #1;
      idle++;
    end
    check("timeout_idle", idle, TMO - 1);
    seq = '{8'h42};
    expect_pkt(seq);
    seq = '{8'hA5, 8'h01, 8'h42, 8'h43};
    send_seq(seq);
    wait_drain(50);
    cnt_model++;
    check("count_after_tmo", pkt_count, cnt_model);

    // maximum-length packet: 00..0F, checksum 10
    seq.delete();
    for (int i = 0; i < 16; i++) seq.push_back(8'(i));
    expect_pkt(seq);
    seq.push_front(8'h10);
    seq.push_front(8'hA5);
    seq.push_back(8'h10);
    send_seq(seq);
    wait_drain(80);
    cnt_model++;
    check("count_max_len", pkt_count, cnt_model);

    // sync value inside payload is data
    seq = '{8'hA5, 8'hA5};
    expect_pkt(seq);
    seq = '{8'hA5, 8'h02, 8'hA5, 8'hA5, 8'h02};
    send_seq(seq);
    wait_drain(50);
    cnt_model++;
    check("count_sync_data", pkt_count, cnt_model);

    // backpressure, with the next packet waiting in the FIFO
    ready_mode = 1;
    seq = '{8'h01, 8'h02, 8'h04, 8'h08};
    expect_pkt(seq);
    seq = '{8'h99};
    expect_pkt(seq);
    seq = '{8'hA5, 8'h04, 8'h01, 8'h02, 8'h04, 8'h08, 8'h0B, 8'hA5, 8'h01, 8'h99, 8'h98};
    send_seq(seq);
    wait_drain(80);
    ready_mode = 0;
    cnt_model += 2;
    check("count_backpressure", pkt_count, cnt_model);

    // frame error mid-payload
    exp_err.push_back(4'b1000);
    seq = '{8'hA5, 8'h03, 8'h10, 8'h20};
    send_seq(seq);
    send(8'h30, 1'b1);
    send(8'h40);
    repeat (3) @(posedge clk);
    #1;
    check("count_after_frame", pkt_count, cnt_model);
    check("frame_err_seen", exp_err.size(), 0);

    // reset during DRAIN
    ready_mode = 2;
    seq = '{8'hC1, 8'hC2};
    expect_pkt(seq);
    seq = '{8'hA5, 8'h02, 8'hC1, 8'hC2, 8'h01};
    send_seq(seq);
    n = 0;
    while (!pkt_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_reached", pkt_valid, 1);
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("rst_valid_low", pkt_valid, 0);
    check("rst_count_zero", pkt_count, 0);
    exp_q.delete();
    cnt_model = 0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    ready_mode = 0;
    seq = '{8'h77};
    expect_pkt(seq);
    seq = '{8'hA5, 8'h01, 8'h77, 8'h76};
    send_seq(seq);
    wait_drain(50);
    cnt_model++;
    check("count_after_reset", pkt_count, cnt_model);

    repeat (3) @(posedge clk);
    #1;
    check("pkt_queue_empty", exp_q.size(), 0);
    check("err_queue_empty", exp_err.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
